// File: rtl/alu_pkg.sv
// Shared opcode encodings, sequencer state type and per-opcode helpers
// used by the ALU sequencer and the ALU itself.
package alu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LOADI = 5'b00001;
  localparam logic [OPC_W-1:0] OP_STORE = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR    = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ADDI  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI   = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV   = 5'b01111;
  localparam logic [OPC_W-1:0] OP_MUL   = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG   = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT   = 5'b10010;
  localparam logic [OPC_W-1:0] OP_BR    = 5'b10011;
  localparam logic [OPC_W-1:0] OP_SHLA  = 5'b11111;
  localparam logic [OPC_W-1:0] OP_MFLO  = 5'b11000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return (op <= OP_BR) || (op == OP_SHLA);
  endfunction

  // Illegal opcodes still take one EXEC cycle so they return an error response.
  function automatic int unsigned op_latency(input logic [OPC_W-1:0] op,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    if (op == OP_MUL) return mul_lat;
    if (op == OP_DIV) return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter timing the EXEC phase; last flags the final cycle.
module alu_lat_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clock) begin
    if (clear)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Presents one request at a time to the ALU, holds it for the opcode's
// latency, captures the result and returns it over a response handshake.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | req_ready high, waiting for a request
//   EXEC    | alu_* driven, latency counter running down
//   RESP    | rsp_valid high, waiting for rsp_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_branch,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_ra,
  output logic [DATA_W-1:0] alu_rb,
  output logic              alu_branch,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err,
  output logic              busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  seq_state_t       state;
  logic             illegal;
  logic             accept;
  logic [CNT_W-1:0] lat_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign req_ready = (state == ST_IDLE) && !clear;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign lat_val   = CNT_W'(op_latency(OPC_W'(req_op), MUL_LAT, DIV_LAT));

  alu_lat_counter #(.W(CNT_W)) u_lat (
    .clock    (clock),
    .clear    (clear),
    .load     (accept),
    .load_val (lat_val),
    .dec      (state == ST_EXEC),
    .count    (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      illegal    <= 1'b0;
      alu_op     <= '0;
      alu_ra     <= '0;
      alu_rb     <= '0;
      alu_branch <= 1'b0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_op     <= req_op;
            alu_ra     <= req_a;
            alu_rb     <= req_b;
            alu_branch <= req_branch;
            illegal    <= !op_legal(OPC_W'(req_op));
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_last) begin
            rsp_hi  <= illegal ? '0 : alu_hi;
            rsp_lo  <= illegal ? '0 : alu_lo;
            rsp_op  <= alu_op;
            rsp_err <= illegal;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural ALU plus a reference of the expected
// response for each request, directed scenarios and a randomized run.
module tb_alu_sequencer;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 1;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [OP_W-1:0]   req_op = '0;
  logic [DATA_W-1:0] req_a = '0;
  logic [DATA_W-1:0] req_b = '0;
  logic              req_branch = 1'b0;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_ra;
  logic [DATA_W-1:0] alu_rb;
  logic              alu_branch;
  logic [DATA_W-1:0] alu_hi;
  logic [DATA_W-1:0] alu_lo;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_hi;
  logic [DATA_W-1:0] rsp_lo;
  logic [OP_W-1:0]   rsp_op;
  logic              rsp_err;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  alu_sequencer #(
    .DATA_W(DATA_W), .OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_branch(req_branch),
    .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_branch(alu_branch),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi),
    .rsp_lo(rsp_lo), .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; illegal codes produce nonzero garbage so zeroing is visible.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic br);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5, 5'd13: return {32'h0, a & b};
      5'd6, 5'd14: return {32'h0, a | b};
      5'd7:  return {32'h0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
      5'd8:  return {32'h0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
      5'd9:  return {32'h0, a >> b[4:0]};
      5'd10: return {32'h0, 32'($signed(a) >>> b[4:0])};
      5'd11, 5'd31: return {32'h0, a << b[4:0]};
      5'd15: return (b == 0) ? 64'h0 : {a % b, a / b};
      5'd16: return {32'h0, a} * {32'h0, b};
      5'd17: return {32'h0, 32'(-a)};
      5'd18: return {32'h0, ~a};
      5'd19: return {32'h0, br ? a + b : a};
      default: return {~a | 32'h1, a ^ b ^ 32'h5a5a5a5a};
    endcase
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (int'(op) <= 19) || (op == 5'd31);
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    if (op == 5'd16) return MUL_LAT;
    if (op == 5'd15) return DIV_LAT;
    return 1;
  endfunction

  assign {alu_hi, alu_lo} = alu_fn(alu_op, alu_ra, alu_rb, alu_branch);

  // One full transaction from IDLE; stall = cycles rsp_ready is held low in RESP.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input int stall, input string tag);
    logic [63:0] exp;
    int n;
    exp = is_legal(op) ? alu_fn(op, a, b, br) : 64'h0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_branch = br;
    rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    n_cmp++;
    if (alu_op !== op || alu_ra !== a || alu_rb !== b || alu_branch !== br || busy !== 1'b1
        || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s drive: op=%h ra=%h rb=%h br=%b busy=%b rdy=%b, required op=%h ra=%h rb=%h br=%b busy=1 rdy=0",
               tag, alu_op, alu_ra, alu_rb, alu_branch, busy, req_ready, op, a, b, br);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n !== exp_lat(op) || rsp_hi !== exp[63:32] || rsp_lo !== exp[31:0] || rsp_op !== op
        || rsp_err !== !is_legal(op) || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s response: lat=%0d hi=%h lo=%h op=%h err=%b rdy=%b, required lat=%0d hi=%h lo=%h op=%h err=%b rdy=0",
               tag, n, rsp_hi, rsp_lo, rsp_op, rsp_err, req_ready, exp_lat(op), exp[63:32],
               exp[31:0], op, !is_legal(op));
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_lo !== exp[31:0] || rsp_hi !== exp[63:32] || req_ready !== 1'b0
          || alu_ra !== a || alu_rb !== b) begin
        n_bad++;
        $display("FAIL %s hold: valid=%b lo=%h hi=%h rdy=%b ra=%h rb=%h, required valid=1 lo=%h hi=%h rdy=0 ra=%h rb=%h",
                 tag, rsp_valid, rsp_lo, rsp_hi, req_ready, alu_ra, alu_rb, exp[31:0], exp[63:32], a, b);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || alu_op !== op || alu_ra !== a) begin
      n_bad++;
      $display("FAIL %s release: valid=%b rdy=%b busy=%b op=%h ra=%h, required valid=0 rdy=1 busy=0 op=%h ra=%h",
               tag, rsp_valid, req_ready, busy, alu_op, alu_ra, op, a);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_active: rdy=%b busy=%b valid=%b, required 0 0 0", req_ready, busy, rsp_valid);
    end
    clear = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1 || alu_op !== '0 || alu_ra !== '0 || alu_rb !== '0 || alu_branch !== 1'b0
        || rsp_hi !== '0 || rsp_lo !== '0 || rsp_op !== '0 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b op=%h ra=%h rb=%h hi=%h lo=%h rop=%h err=%b, required rdy=1 rest 0",
               req_ready, alu_op, alu_ra, alu_rb, rsp_hi, rsp_lo, rsp_op, rsp_err);
    end
  endtask

  task automatic test_add();
    do_op(5'd3, 32'd5, 32'd7, 1'b0, 0, "add");
  endtask

  task automatic test_mul();
    do_op(5'd16, 32'h0001_0000, 32'h0001_0000, 1'b0, 1, "mul");
  endtask

  task automatic test_div();
    do_op(5'd15, 32'd100, 32'd7, 1'b0, 0, "div");
  endtask

  task automatic test_back_to_back();
    int n;
    do_op(5'd3, 32'd2, 32'd2, 1'b0, 0, "b2b_warm");
    req_valid = 1'b1; req_op = 5'd3; req_a = 32'd1; req_b = 32'd1; req_branch = 1'b0;
    @(negedge clock);
    req_op = 5'd4; req_a = 32'd9; req_b = 32'd4;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_lo !== 32'd2 || req_ready !== 1'b0 || alu_op !== 5'd3) begin
        n_bad++;
        $display("FAIL backpressure: valid=%b lo=%h rdy=%b op=%h, required valid=1 lo=2 rdy=0 op=03",
                 rsp_valid, rsp_lo, req_ready, alu_op);
      end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || alu_op !== 5'd3) begin
      n_bad++;
      $display("FAIL b2b_idle: rdy=%b busy=%b op=%h, required rdy=1 busy=0 op=03", req_ready, busy, alu_op);
    end
    @(negedge clock);
    req_valid = 1'b0;
    n_cmp++;
    if (alu_op !== 5'd4 || alu_ra !== 32'd9 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: op=%h ra=%h busy=%b, required op=04 ra=9 busy=1", alu_op, alu_ra, busy);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n !== 1 || rsp_lo !== 32'd5 || rsp_op !== 5'd4) begin
      n_bad++;
      $display("FAIL b2b_second: lat=%0d lo=%h op=%h, required lat=1 lo=5 op=04", n, rsp_lo, rsp_op);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    do_op(5'd24, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 0, "illegal");
    do_op(5'd3, 32'd10, 32'd20, 1'b0, 0, "after_illegal");
  endtask

  task automatic test_clear_mid();
    req_valid = 1'b1; req_op = 5'd16; req_a = 32'd6; req_b = 32'd7; req_branch = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || alu_op !== '0 || alu_ra !== '0
        || alu_rb !== '0 || alu_branch !== 1'b0 || rsp_hi !== '0 || rsp_lo !== '0 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_mid: busy=%b valid=%b rdy=%b op=%h ra=%h rb=%h br=%b hi=%h lo=%h, required all 0",
               busy, rsp_valid, req_ready, alu_op, alu_ra, alu_rb, alu_branch, rsp_hi, rsp_lo);
    end
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL clear_quiet: valid=%b rdy=%b, required valid=0 rdy=1", rsp_valid, req_ready);
      end
    end
    do_op(5'd3, 32'd3, 32'd4, 1'b0, 0, "after_clear");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (i % 5 == 0) op = 5'd16;
      if (i % 7 == 0) op = 5'd15;
      do_op(op, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_back_to_back();
    test_illegal();
    test_clear_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
